rpn_sequencer: RTL

- Program sequencer for the 16-bit RPN stack calculator, clocked by the same `step` clock.
- Holds a small instruction memory, loaded through a write port.
- On `start`, issues one calculator command per cycle: push immediate, negate, add or multiply.
- Keeps a shadow copy of the stack depth to catch underflow/overflow before issuing, then captures the final top-of-stack as `result` and checks the calculator's depth against its shadow.

---
 rtl/rpn_sequencer_if.sv | 30 +++
 rtl/rpn_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/rpn_sequencer_if.sv
// Sequencer bus: instruction-memory write port, run control, calculator command/status, run results.
// master is the sequencer itself; slave is the host plus the calculator.
interface rpn_sequencer_if #(parameter int AW = 5);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [17:0]   wr_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          abort;
    logic [15:0]   calc_out;
    logic [9:0]    calc_cnt;
    logic          calc_push;
    logic [1:0]    calc_op;
    logic [15:0]   calc_d;
    logic          busy;
    logic          done;
    logic [2:0]    err;
    logic [15:0]   result;
    logic [AW:0]   pc;

    modport master (
        input  wr_en, wr_addr, wr_data, prog_len, start, abort, calc_out, calc_cnt,
        output calc_push, calc_op, calc_d, busy, done, err, result, pc
    );

    modport slave (
        output wr_en, wr_addr, wr_data, prog_len, start, abort, calc_out, calc_cnt,
        input  calc_push, calc_op, calc_d, busy, done, err, result, pc
    );
endinterface

// File: rtl/rpn_sequencer.sv
// RPN program sequencer: one registered calculator command per cycle, done L+2 edges after start.
// No backpressure; illegal stack use or abort ends the run early and returns to IDLE.
module rpn_sequencer #(
    parameter int AW        = 5,
    parameter int DEPTH_MAX = 1000
) (
    input  logic          step,
    input  logic          nrst,
    rpn_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

    localparam logic [9:0] DMAX   = 10'(DEPTH_MAX);
    localparam logic [1:0] K_PUSH = 2'd0;
    localparam logic [1:0] K_NEG  = 2'd1;

    logic [17:0] mem [2**AW];
    state_t      state;
    logic [9:0]  depth;
    logic [AW:0] len;

    logic [17:0] instr;
    logic [1:0]  kind;
    logic        legal;
    logic        over;
    logic [AW:0] pc_next;

    always_ff @(posedge step) begin
        if (bus.wr_en && state == IDLE) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Legality is judged on the shadow depth so nothing illegal ever reaches the calculator.
    always_comb begin
        instr   = mem[bus.pc[AW-1:0]];
        kind    = instr[17:16];
        pc_next = bus.pc + 1'b1;
        over    = 1'b0;
        case (kind)
            K_PUSH: begin
                legal = depth < DMAX;
                over  = 1'b1;
            end
            K_NEG:   legal = depth != 10'd0;
            default: legal = depth >= 10'd2;
        endcase
    end

    always_ff @(posedge step or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            depth         <= '0;
            len           <= '0;
            bus.calc_push <= 1'b0;
            bus.calc_op   <= 2'd0;
            bus.calc_d    <= 16'd0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 3'd0;
            bus.result    <= 16'd0;
            bus.pc        <= '0;
        end else begin
            bus.calc_push <= 1'b0;
            bus.calc_op   <= 2'd0;
            bus.done      <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.start && !bus.abort) begin
                            bus.pc   <= '0;
                            depth    <= bus.calc_cnt;
                            bus.err  <= 3'd0;
                            len      <= bus.prog_len;
                            bus.busy <= 1'b1;
                            state    <= (bus.prog_len != '0) ? RUN : FIN;
                        end
                    end
                    RUN: begin
                        if (legal) begin
                            if (kind == K_PUSH) begin
                                bus.calc_push <= 1'b1;
                                bus.calc_d    <= instr[15:0];
                                depth         <= depth + 1'b1;
                            end else if (kind == K_NEG) begin
                                bus.calc_op <= kind;
                            end else begin
                                bus.calc_op <= kind;
                                depth       <= depth - 1'b1;
                            end
                            bus.pc <= pc_next;
                            if (pc_next == len) begin
                                state <= DRAIN;
                            end
                        end else begin
                            bus.err  <= over ? 3'd2 : 3'd1;
                            bus.busy <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                    DRAIN: state <= FIN;
                    FIN: begin
                        bus.result <= bus.calc_out;
                        if (bus.calc_cnt != depth) begin
                            bus.err <= 3'd3;
                        end
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
